mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths fixed by rv32i_types.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 ex_mem  in  ex_mem_stage_reg_t  instruction leaving execute, including alu_out, br_en, rs2_v, funct3, opcode, rd_s, regf_we, regfilemux_sel, u_imm, pc and valid.
REQ-005 dmem_addr  out  32  word-aligned data address, {alu_out[31:2],2'b00}.
REQ-006 dmem_rmask  out  4  byte read enables; nonzero means a load request.
REQ-007 dmem_wmask  out  4  byte write enables; nonzero means a store request.
REQ-008 dmem_wdata  out  32  store data, lane-shifted.
REQ-009 dmem_rdata  in  32  load data; valid when dmem_resp=1.
REQ-010 dmem_resp  in  1  one-cycle completion pulse from data memory.
REQ-011 mem_stall  out  1  holds upstream stages and the ex_mem register.
REQ-012 mem_wb  out  mem_wb_stage_reg_t  registered payload to writeback, plus load_data[31:0].

Function
REQ-013 mem_op = ex_mem.valid and opcode is load or store.
- Non-mem valid instruction: both masks 0; passes to mem_wb next edge; latency 1.
REQ-014 Masks by funct3 and offset a=alu_out[1:0]:
- byte: 4'b0001<<a
- half: 4'b0011<<a
- word: 4'b1111
REQ-015 Store data:
- SB: dmem_wdata = rs2_v[7:0] replicated to all 4 lanes.
- SH: rs2_v[15:0] replicated to both halves.
- SW: rs2_v unchanged.
REQ-016 FSM has states IDLE and WAIT; state resets to IDLE.
- IDLE and mem_op with dmem_resp=0: go to WAIT.
- IDLE and mem_op with dmem_resp=1: stay IDLE (zero-wait completion).
- WAIT and dmem_resp=1: go to IDLE.
REQ-017 Request timing:
- The request is driven combinationally from ex_mem starting in the IDLE cycle.
- addr, masks and wdata stay stable until and including the dmem_resp cycle.
REQ-018 mem_stall = mem_op and not dmem_resp.
- Asserted in both IDLE and WAIT.
- Deasserted in the resp cycle so upstream advances on that edge.
REQ-019 While mem_stall=1, mem_wb.valid <= 0 (bubble); the other mem_wb fields are don't-care.
REQ-020 On the resp edge:
- mem_wb captures the ex_mem payload with valid=1.
- load_data is extracted from dmem_rdata>>(8*a).
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-021 Store completion: load_data=0 and regf_we passes through unchanged (expected 0).
REQ-022 dmem_resp arriving with no request outstanding is ignored; state is unchanged.
REQ-023 ex_mem.valid=0: both masks 0, no request, mem_wb.valid <= 0.
REQ-024 Back-to-back mem ops: the second request is driven in the cycle after the first resp; no idle cycle is inserted.

Reset
REQ-025 rst low asynchronously forces:
- state=IDLE
- all mem_wb fields 0 (valid=0, inst=32'h00000013)
REQ-026 rst asserted during WAIT abandons the request: masks go to 0 immediately (combinational from state/valid) and a later dmem_resp is ignored per REQ-022.

Configuration
REQ-027 Macro MISALIGN_TRAP_EN.
- Defined: a half access with a[0]=1, or a word access with a!=0, issues no request (masks 0) and does not stall. mem_wb gets valid=1, regf_we=0, and the misalign flag set to 1.
- Undefined: there is no misalign flag; misaligned accesses issue the masks of REQ-014 (bits shifted out are dropped).

Structure
REQ-028 The following live in rv32i_types:
- mem_wb_stage_reg_t
- the mem_state_t enum {IDLE, WAIT}
- load/store funct3 constants
REQ-029 The combinational unit load_align (funct3, offset, rdata -> load_data) is a separate sub-module; the FSM and registers stay in mem_stage.

Verification
REQ-030 SW rs2_v=32'hDEADBEEF, alu_out=32'h100, resp after 3 cycles -> addr=32'h100, wmask=4'hF, mem_stall high 3 cycles, one mem_wb.valid pulse.
REQ-031 LB alu_out=32'h203, rdata=32'h80FF_FF00, zero-wait resp -> mem_stall never high, rmask=4'b1000, load_data=32'hFFFFFF80.
REQ-032 LHU alu_out=32'h302, rdata=32'hBEEF_0000 -> rmask=4'b1100, load_data=32'h0000BEEF.
REQ-033 SB then LW back-to-back, each with 1-cycle resp -> second request starts the cycle after the first resp; no bubble between the mem_wb valid pulses.
REQ-034 rst low during WAIT, then dmem_resp pulse -> state IDLE, masks 0, mem_wb.valid stays 0.
REQ-035 With MISALIGN_TRAP_EN, LW alu_out=32'h101 -> masks 0, no stall, mem_wb.misalign=1, regf_we=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared RV32I pipeline types for the memory stage: stage registers, FSM states, funct3 codes.
// Build option: MISALIGN_TRAP_EN adds a misalign flag to the writeback payload.
package rv32i_types;

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] rs2_v;
    logic [31:0] u_imm;
    logic        br_en;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic [4:0]  rd_s;
    logic        regf_we;
    logic [3:0]  regfilemux_sel;
    logic        valid;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] u_imm;
    logic [31:0] load_data;
    logic        br_en;
    logic [4:0]  rd_s;
    logic        regf_we;
    logic [3:0]  regfilemux_sel;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif
    logic        valid;
  } mem_wb_stage_reg_t;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic [3:0] access_mask(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b00:   access_mask = 4'b0001 << offset;
      2'b01:   access_mask = 4'b0011 << offset;
      default: access_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and data memory (slave).
interface mem_stage_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: selects the addressed byte/half/word and extends it.
module load_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_data_o = shifted;
      F3_LBU:  load_data_o = {24'h000000, shifted[7:0]};
      F3_LHU:  load_data_o = {16'h0000, shifted[15:0]};
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: drives data-memory requests from ex_mem, stalls until dmem_resp, registers mem_wb.
// Build option: MISALIGN_TRAP_EN turns misaligned half/word accesses into flagged, request-free completions.
module mem_stage
  import rv32i_types::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  ex_mem_stage_reg_t  ex_mem_i,
  mem_stage_if.master        dmem,
  output logic               mem_stall_o,
  output mem_wb_stage_reg_t  mem_wb_o
);

  mem_state_t        state_q, state_d;
  mem_wb_stage_reg_t mem_wb_q, mem_wb_d;

  logic        is_store;
  logic        mem_op;
  logic        trap;
  logic        req;
  logic [1:0]  offset;
  logic [3:0]  mask;
  logic [31:0] store_data;
  logic [31:0] load_data;

  assign offset   = ex_mem_i.alu_out[1:0];
  assign is_store = (ex_mem_i.opcode == OP_STORE);
  assign mem_op   = ex_mem_i.valid && ((ex_mem_i.opcode == OP_LOAD) || is_store);

`ifdef MISALIGN_TRAP_EN
  assign trap = mem_op && is_misaligned(ex_mem_i.funct3, offset);
`else
  assign trap = 1'b0;
`endif

  assign req  = mem_op && !trap;
  assign mask = access_mask(ex_mem_i.funct3, offset);

  // Each byte lane picks its source byte of rs2_v according to the store size.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_data[8*gi +: 8] =
        (ex_mem_i.funct3[1:0] == 2'b00) ? ex_mem_i.rs2_v[7:0] :
        (ex_mem_i.funct3[1:0] == 2'b01) ? ex_mem_i.rs2_v[8*(gi%2) +: 8] :
                                          ex_mem_i.rs2_v[8*gi +: 8];
  end

  assign dmem.dmem_addr  = {ex_mem_i.alu_out[31:2], 2'b00};
  assign dmem.dmem_rmask = (req && !is_store) ? mask : 4'b0000;
  assign dmem.dmem_wmask = (req &&  is_store) ? mask : 4'b0000;
  assign dmem.dmem_wdata = store_data;
  assign mem_stall_o     = req && !dmem.dmem_resp;

  load_align u_load_align (
    .funct3_i    (ex_mem_i.funct3),
    .offset_i    (offset),
    .rdata_i     (dmem.dmem_rdata),
    .load_data_o (load_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req && !dmem.dmem_resp) state_d = WAIT;
      WAIT:    if (dmem.dmem_resp)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A valid instruction retires when it needs no memory, traps, or sees its response.
  always_comb begin
    mem_wb_d       = mem_wb_q;
    mem_wb_d.valid = 1'b0;
    if (ex_mem_i.valid && (!mem_op || trap || dmem.dmem_resp)) begin
      mem_wb_d.inst           = ex_mem_i.inst;
      mem_wb_d.pc             = ex_mem_i.pc;
      mem_wb_d.alu_out        = ex_mem_i.alu_out;
      mem_wb_d.u_imm          = ex_mem_i.u_imm;
      mem_wb_d.br_en          = ex_mem_i.br_en;
      mem_wb_d.rd_s           = ex_mem_i.rd_s;
      mem_wb_d.regfilemux_sel = ex_mem_i.regfilemux_sel;
      mem_wb_d.regf_we        = trap ? 1'b0 : ex_mem_i.regf_we;
      mem_wb_d.load_data      = (req && !is_store) ? load_data : 32'h0;
`ifdef MISALIGN_TRAP_EN
      mem_wb_d.misalign       = trap;
`endif
      mem_wb_d.valid          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_wb_q      <= '0;
      mem_wb_q.inst <= NOP_INST;
    end else begin
      state_q  <= state_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign mem_wb_o = mem_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors plus randomized loads/stores against a byte-level model.
module tb_mem_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  ex_mem_stage_reg_t ex_mem;
  mem_wb_stage_reg_t mem_wb;
  logic              mem_stall;
  int                total = 0;
  int                bad = 0;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_mem_i    (ex_mem),
    .dmem        (dmem),
    .mem_stall_o (mem_stall),
    .mem_wb_o    (mem_wb)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    int n, off;
    n = size_bytes(f3);
    off = int'(a);
    m = 4'h0;
    if (n == 4) return 4'hF;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (size_bytes(f3) == 1) return (rs2 & 32'hFF) * 32'h01010101;
    if (size_bytes(f3) == 2) return (rs2 & 32'hFFFF) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rdata);
    logic [31:0] s, v;
    s = rdata >> (int'(a) * 8);
    case (f3)
      F3_LB:  begin v = s & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      F3_LH:  begin v = s & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      F3_LBU: v = s & 32'hFF;
      F3_LHU: v = s & 32'hFFFF;
      default: v = s;
    endcase
    return v;
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input logic [1:0] a);
    int n;
    n = size_bytes(f3);
    return (n == 2 && a[0]) || (n == 4 && a != 2'b00);
  endfunction

  // ---------------- transaction driver ----------------
  task automatic drive_mem_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [31:0] rdata, input int waits);
    logic [3:0]  em, want_r, want_w;
    logic [31:0] want_wd, want_ld, pc;
    logic [4:0]  rd;
    pc      = $urandom;
    rd      = 5'($urandom_range(1, 31));
    em      = exp_mask(f3, addr[1:0]);
    want_r  = st ? 4'h0 : em;
    want_w  = st ? em : 4'h0;
    want_wd = exp_wdata(f3, rs2);
    want_ld = st ? 32'h0 : exp_load(f3, addr[1:0], rdata);
    @(negedge clk);
    ex_mem                = '0;
    ex_mem.inst           = $urandom;
    ex_mem.pc             = pc;
    ex_mem.alu_out        = addr;
    ex_mem.rs2_v          = rs2;
    ex_mem.u_imm          = $urandom;
    ex_mem.funct3         = f3;
    ex_mem.opcode         = st ? OP_STORE : OP_LOAD;
    ex_mem.rd_s           = rd;
    ex_mem.regf_we        = !st;
    ex_mem.regfilemux_sel = 4'($urandom_range(0, 15));
    ex_mem.valid          = 1'b1;
    dmem.dmem_resp        = 1'b0;
    dmem.dmem_rdata       = $urandom;
    for (int c = 0; c <= waits; c++) begin
      if (c == waits) begin
        dmem.dmem_resp  = 1'b1;
        dmem.dmem_rdata = rdata;
      end
      #1;
      total++;
      if ({dmem.dmem_rmask, dmem.dmem_wmask} !== {want_r, want_w}) begin
        bad++;
        $display("FAIL masks addr=%h cyc=%0d: rmask/wmask got %h/%h want %h/%h",
                 addr, c, dmem.dmem_rmask, dmem.dmem_wmask, want_r, want_w);
      end
      total++;
      if (dmem.dmem_addr !== {addr[31:2], 2'b00}) begin
        bad++;
        $display("FAIL dmem_addr: got %h want %h", dmem.dmem_addr, {addr[31:2], 2'b00});
      end
      if (st) begin
        total++;
        if (dmem.dmem_wdata !== want_wd) begin
          bad++;
          $display("FAIL wdata f3=%0d: got %h want %h", f3, dmem.dmem_wdata, want_wd);
        end
      end
      total++;
      if (mem_stall !== 1'(c != waits)) begin
        bad++;
        $display("FAIL mem_stall cyc=%0d/%0d: got %b want %b", c, waits, mem_stall, c != waits);
      end
      @(posedge clk);
      #1;
      total++;
      if (mem_wb.valid !== 1'(c == waits)) begin
        bad++;
        $display("FAIL mem_wb.valid cyc=%0d/%0d: got %b want %b", c, waits, mem_wb.valid, c == waits);
      end
      if (c < waits) @(negedge clk);
    end
    total++;
    if (mem_wb.load_data !== want_ld) begin
      bad++;
      $display("FAIL load_data f3=%0d addr=%h rdata=%h: got %h want %h", f3, addr, rdata, mem_wb.load_data, want_ld);
    end
    total++;
    if ({mem_wb.pc, mem_wb.rd_s, mem_wb.regf_we} !== {pc, rd, !st}) begin
      bad++;
      $display("FAIL payload: got pc=%h rd=%0d we=%b want pc=%h rd=%0d we=%b",
               mem_wb.pc, mem_wb.rd_s, mem_wb.regf_we, pc, rd, !st);
    end
`ifdef MISALIGN_TRAP_EN
    total++;
    if (mem_wb.misalign !== 1'b0) begin
      bad++;
      $display("FAIL misalign flag on aligned op: got %b want 0", mem_wb.misalign);
    end
`endif
    $display("txn %s f3=%0d addr=%h rs2=%h rdata=%h waits=%0d load_data=%h",
             st ? "store" : "load ", f3, addr, rs2, rdata, waits, mem_wb.load_data);
  endtask

  task automatic go_idle();
    @(negedge clk);
    ex_mem.valid   = 1'b0;
    dmem.dmem_resp = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (mem_wb.valid !== 1'b0) begin
      bad++;
      $display("FAIL idle mem_wb.valid: got %b want 0", mem_wb.valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ex_mem          = '0;
    dmem.dmem_resp  = 1'b0;
    dmem.dmem_rdata = '0;
    rst_n           = 1'b0;
    #12;
    total++;
    if ({mem_wb.valid, mem_wb.inst, mem_wb.pc, mem_wb.load_data, mem_wb.regf_we} !==
        {1'b0, 32'h00000013, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset mem_wb: got valid=%b inst=%h pc=%h ld=%h we=%b",
               mem_wb.valid, mem_wb.inst, mem_wb.pc, mem_wb.load_data, mem_wb.regf_we);
    end
    total++;
    if ({mem_stall, dmem.dmem_rmask, dmem.dmem_wmask} !== 9'h0) begin
      bad++;
      $display("FAIL reset outputs: got stall=%b rmask=%h wmask=%h", mem_stall, dmem.dmem_rmask, dmem.dmem_wmask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_directed();
    drive_mem_op(1'b1, F3_SW,  32'h100, 32'hDEADBEEF, 32'h0, 3);
    go_idle();
    drive_mem_op(1'b0, F3_LB,  32'h203, 32'h0, 32'h80FFFF00, 0);
    drive_mem_op(1'b0, F3_LHU, 32'h302, 32'h0, 32'hBEEF0000, 1);
    drive_mem_op(1'b1, F3_SH,  32'h406, 32'h1234ABCD, 32'h0, 2);
    drive_mem_op(1'b0, F3_LH,  32'h500, 32'h0, 32'h00008001, 0);
`ifndef MISALIGN_TRAP_EN
    drive_mem_op(1'b0, F3_LW,  32'h101, 32'h0, 32'hCAFEF00D, 1);
    drive_mem_op(1'b1, F3_SH,  32'h603, 32'h0000A55A, 32'h0, 0);
`endif
    go_idle();
  endtask

  task automatic test_non_mem();
    logic [31:0] alu;
    for (int i = 0; i < 4; i++) begin
      alu = $urandom;
      @(negedge clk);
      ex_mem         = '0;
      ex_mem.alu_out = alu;
      ex_mem.opcode  = (i == 3) ? 7'b0010011 : 7'b0110011;
      ex_mem.regf_we = 1'b1;
      ex_mem.valid   = 1'b1;
      #1;
      total++;
      if ({mem_stall, dmem.dmem_rmask, dmem.dmem_wmask} !== 9'h0) begin
        bad++;
        $display("FAIL non-mem request: got stall=%b rmask=%h wmask=%h", mem_stall, dmem.dmem_rmask, dmem.dmem_wmask);
      end
      @(posedge clk);
      #1;
      total++;
      if ({mem_wb.valid, mem_wb.alu_out, mem_wb.load_data} !== {1'b1, alu, 32'h0}) begin
        bad++;
        $display("FAIL non-mem pass: got valid=%b alu=%h ld=%h want 1 %h 0", mem_wb.valid, mem_wb.alu_out, mem_wb.load_data, alu);
      end
      $display("txn non-mem alu_out=%h", alu);
    end
    @(negedge clk);
    ex_mem.opcode = OP_LOAD;
    ex_mem.valid  = 1'b0;
    #1;
    total++;
    if ({mem_stall, dmem.dmem_rmask, dmem.dmem_wmask} !== 9'h0) begin
      bad++;
      $display("FAIL invalid load request: got stall=%b rmask=%h wmask=%h", mem_stall, dmem.dmem_rmask, dmem.dmem_wmask);
    end
    @(posedge clk);
    #1;
    total++;
    if (mem_wb.valid !== 1'b0) begin
      bad++;
      $display("FAIL invalid load mem_wb.valid: got %b want 0", mem_wb.valid);
    end
    $display("txn invalid load bubble");
  endtask

  task automatic test_stray_resp();
    @(negedge clk);
    ex_mem.valid   = 1'b0;
    dmem.dmem_resp = 1'b1;
    #1;
    total++;
    if ({mem_stall, dmem.dmem_rmask, dmem.dmem_wmask} !== 9'h0) begin
      bad++;
      $display("FAIL stray resp outputs: got stall=%b rmask=%h wmask=%h", mem_stall, dmem.dmem_rmask, dmem.dmem_wmask);
    end
    @(posedge clk);
    #1;
    total++;
    if (mem_wb.valid !== 1'b0) begin
      bad++;
      $display("FAIL stray resp mem_wb.valid: got %b want 0", mem_wb.valid);
    end
    $display("txn stray resp ignored");
    drive_mem_op(1'b0, F3_LW, 32'h700, 32'h0, 32'h13572468, 2);
    go_idle();
  endtask

  task automatic test_back_to_back();
    drive_mem_op(1'b1, F3_SB, 32'h801, 32'h000000A7, 32'h0, 0);
    drive_mem_op(1'b0, F3_LW, 32'h804, 32'h0, 32'h89ABCDEF, 0);
    drive_mem_op(1'b0, F3_LBU, 32'h806, 32'h0, 32'h00F70000, 0);
    drive_mem_op(1'b1, F3_SW, 32'h808, 32'h01020304, 32'h0, 1);
    go_idle();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    ex_mem         = '0;
    ex_mem.alu_out = 32'h900;
    ex_mem.rs2_v   = 32'h55AA55AA;
    ex_mem.funct3  = F3_SW;
    ex_mem.opcode  = OP_STORE;
    ex_mem.valid   = 1'b1;
    dmem.dmem_resp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n        = 1'b0;
    ex_mem.valid = 1'b0;
    #1;
    total++;
    if ({dmem.dmem_rmask, dmem.dmem_wmask, mem_stall, mem_wb.valid, mem_wb.inst} !== {9'h0, 1'b0, 32'h00000013}) begin
      bad++;
      $display("FAIL reset in wait: got rmask=%h wmask=%h stall=%b valid=%b inst=%h",
               dmem.dmem_rmask, dmem.dmem_wmask, mem_stall, mem_wb.valid, mem_wb.inst);
    end
    @(negedge clk);
    rst_n          = 1'b1;
    dmem.dmem_resp = 1'b1;
    #1;
    total++;
    if ({dmem.dmem_rmask, dmem.dmem_wmask, mem_stall} !== 9'h0) begin
      bad++;
      $display("FAIL late resp outputs: got rmask=%h wmask=%h stall=%b", dmem.dmem_rmask, dmem.dmem_wmask, mem_stall);
    end
    @(posedge clk);
    #1;
    total++;
    if (mem_wb.valid !== 1'b0) begin
      bad++;
      $display("FAIL late resp mem_wb.valid: got %b want 0", mem_wb.valid);
    end
    $display("txn reset during wait, late resp ignored");
    go_idle();
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    logic [31:0] addrs [3];
    logic [2:0]  f3s   [3];
    addrs = '{32'h101, 32'h203, 32'h306};
    f3s   = '{F3_LW, F3_SH, F3_SW};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_mem         = '0;
      ex_mem.alu_out = addrs[i];
      ex_mem.funct3  = f3s[i];
      ex_mem.opcode  = (i == 0) ? OP_LOAD : OP_STORE;
      ex_mem.regf_we = (i == 0);
      ex_mem.valid   = 1'b1;
      dmem.dmem_resp = 1'b0;
      #1;
      total++;
      if ({dmem.dmem_rmask, dmem.dmem_wmask, mem_stall} !== 9'h0) begin
        bad++;
        $display("FAIL misalign request: got rmask=%h wmask=%h stall=%b", dmem.dmem_rmask, dmem.dmem_wmask, mem_stall);
      end
      @(posedge clk);
      #1;
      total++;
      if ({mem_wb.valid, mem_wb.misalign, mem_wb.regf_we} !== 3'b110) begin
        bad++;
        $display("FAIL misalign mem_wb: got valid=%b misalign=%b we=%b want 1 1 0",
                 mem_wb.valid, mem_wb.misalign, mem_wb.regf_we);
      end
      $display("txn misaligned f3=%0d addr=%h trapped", f3s[i], addrs[i]);
    end
    go_idle();
  endtask
`endif

  task automatic test_random();
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = F3_LB;
          1: f3 = F3_LH;
          2: f3 = F3_LW;
          3: f3 = F3_LBU;
          default: f3 = F3_LHU;
        endcase
      end
      addr = $urandom;
`ifdef MISALIGN_TRAP_EN
      while (model_misaligned(f3, addr[1:0])) addr = $urandom;
`endif
      drive_mem_op(st, f3, addr, $urandom, $urandom, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_non_mem();
    test_stray_resp();
    test_back_to_back();
    test_reset_in_wait();
`ifdef MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
